// File: rtl/hssl_link_monitor.sv
// HSSL link monitor: classifies incoming GTH words, tracks sync acquisition
// and loss of lock, and keeps saturating/wrapping link statistics for a VIO.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// LOST   | no alignment; waiting for the first sync word
// HUNT   | counting consecutive sync words towards LOCK_CNT
// LOCKED | link up; bad words are counted per 256-word error window
module hssl_link_monitor #(
    parameter int         LOCK_CNT  = 64,
    parameter int         ERR_THR   = 8,
    parameter logic [7:0] SYNC_CHAR = 8'hBC,
    parameter logic [7:0] SOF_CHAR  = 8'hFB
) (
    input  logic        hsslif_clk,
    input  logic        hsslif_reset,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_charisk,
    input  logic        rx_valid,
    input  logic        stats_clear,
    output logic [2:0]  link_state,
    output logic        link_up,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [31:0] up_cycles
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int ERR_W = $clog2(ERR_THR + 1);

    // Last run value before lock: the sync word arriving at this count is
    // the LOCK_CNT-th one.
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(ERR_THR);

    typedef enum logic [2:0] {
        ST_LOST   = 3'b001,
        ST_HUNT   = 3'b010,
        ST_LOCKED = 3'b100
    } link_state_t;

    link_state_t      state_q;
    link_state_t      state_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [7:0]       win_q;
    logic [7:0]       win_d;
    logic [ERR_W-1:0] werr_q;
    logic [ERR_W-1:0] werr_d;

    logic [15:0]      frame_q;
    logic [15:0]      err_q;
    logic [31:0]      up_q;
    logic             clr_q;
    logic             clr_rise;

    logic             word_k0;
    logic             word_sync;
    logic             word_sof;
    logic             word_data;
    logic             word_bad;

    // Only the low byte carries the control character; upper bytes are payload.
    logic             unused_rx_hi;
    assign unused_rx_hi = ^rx_data[31:8];

    // Word classification, gated by rx_valid so every class implies a real word.
    always_comb begin
        word_k0   = (rx_charisk == 4'b0001);
        word_sync = rx_valid && word_k0 && (rx_data[7:0] == SYNC_CHAR);
        word_sof  = rx_valid && word_k0 && (rx_data[7:0] == SOF_CHAR);
        word_data = rx_valid && (rx_charisk == 4'b0000);
        word_bad  = rx_valid && !(word_sync || word_sof || word_data);
    end

    // Next-state and lock-tracking counters; everything holds while rx_valid is low.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        win_d   = win_q;
        werr_d  = werr_q;
        case (state_q)
            ST_LOST: begin
                if (word_sync) begin
                    state_d = ST_HUNT;
                    run_d   = RUN_W'(1);
                end
            end
            ST_HUNT: begin
                if (rx_valid) begin
                    if (word_sync) begin
                        if (run_q == RUN_LAST) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        state_d = ST_LOST;
                        run_d   = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (rx_valid) begin
                    win_d = win_q + 8'd1;
                    // The threshold test uses the count before any window-wrap
                    // clear, so a bad word landing on the wrap still counts.
                    if (word_bad && (werr_q + ERR_W'(1) == ERR_LIMIT)) begin
                        state_d = ST_LOST;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == 8'hFF) begin
                        werr_d = '0;
                    end else if (word_bad) begin
                        werr_d = werr_q + ERR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOST;
                run_d   = '0;
                win_d   = '0;
                werr_d  = '0;
            end
        endcase
    end

    // FSM state and lock-tracking counter registers.
    always_ff @(posedge hsslif_clk) begin
        if (hsslif_reset) begin
            state_q <= ST_LOST;
            run_q   <= '0;
            win_q   <= '0;
            werr_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
        end
    end

    // A VIO level becomes a one-cycle clear on its rising edge.
    assign clr_rise = stats_clear && !clr_q;

    // Statistics counters; a clear beats any same-cycle increment.
    always_ff @(posedge hsslif_clk) begin
        if (hsslif_reset) begin
            clr_q   <= 1'b0;
            frame_q <= '0;
            err_q   <= '0;
            up_q    <= '0;
        end else begin
            clr_q <= stats_clear;
            if (clr_rise) begin
                frame_q <= '0;
                err_q   <= '0;
                up_q    <= '0;
            end else if (state_q == ST_LOCKED) begin
                up_q <= up_q + 32'd1;
                if (word_sof && (frame_q != 16'hFFFF)) begin
                    frame_q <= frame_q + 16'd1;
                end
                if (word_bad && (err_q != 16'hFFFF)) begin
                    err_q <= err_q + 16'd1;
                end
            end
        end
    end

    assign link_state = state_q;
    assign link_up    = state_q[2];
    assign frame_cnt  = frame_q;
    assign err_cnt    = err_q;
    assign up_cycles  = up_q;

endmodule
